compare_seq_n: RTL and testbench
================================

Name: compare_seq_n

Overview:
- Multi-cycle, parametrised magnitude comparator. It is the next generation of the team's 4-bit combinational Equal/Alarger/Blarger comparator.
- Compares two WIDTH-bit operands, CHUNK bits per clock, MSB chunk first.
- Supports signed and unsigned modes, with optional early exit on the first differing chunk.
- Sits between operand registers and control logic that needs a one-hot Equal/Alarger/Blarger result with a start/done handshake.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- EARLY_EXIT, 1, 1 = finish on the first differing chunk; 0 = always scan all chunks (fixed latency).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a compare; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement compare; 0 = unsigned; latched with start.
- a  in  WIDTH  operand A; latched on an accepted start.
- b  in  WIDTH  operand B; latched on an accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a result is updated.
- equal  out  1  A == B.
- a_larger  out  1  A > B.
- b_larger  out  1  A < B.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, equal, a_larger, b_larger all 0; chunk index = NCHUNK-1, where NCHUNK = WIDTH/CHUNK. Applies immediately, including mid-RUN; the in-flight compare is discarded with no done.
- States: IDLE, RUN.
- IDLE -> RUN on start=1 at edge T:
  - latch a, b, signed_mode; set index = NCHUNK-1; busy=1.
  - In signed mode, invert the MSB of both latched operands, then compare unsigned (offset-binary trick).
- RUN: each edge compares latched chunk [index*CHUNK +: CHUNK] of A against B.
  - EARLY_EXIT=1, chunks differ: register result (a_larger or b_larger), pulse done, return to IDLE.
  - EARLY_EXIT=0: the first differing chunk is captured in a sticky internal flag; later chunks are ignored; result is registered at index 0.
  - index==0 with all chunks equal: equal=1.
  - Otherwise: decrement index.
- Latency: the k-th examined chunk is compared at edge T+k.
  - done is high in the cycle following edge T+k; k = NCHUNK when EARLY_EXIT=0 or the operands are equal.
  - Minimum latency is 1 cycle (top chunk differs, EARLY_EXIT=1).
- Outputs:
  - equal/a_larger/b_larger update only on the done edge and are held until the next done or reset.
  - Exactly one flag is high after the first done; all three are 0 before it.
- done is high for exactly one cycle; busy falls on the same edge done rises.
- start while busy is ignored and not queued. Changes on a, b or signed_mode during RUN have no effect.
- start in the cycle done is high is accepted (IDLE at that edge), giving back-to-back compares with one idle cycle between RUN periods.
- CHUNK == WIDTH degenerates to a 1-cycle compare; the index counter is width max(1, clog2(NCHUNK)).

Decomposition:
- Shared package cmp_pkg:
  - state enum {IDLE, RUN}.
  - result encoding constants (EQ, AGT, BGT).
  - function computing NCHUNK and counter width.
- One natural sub-module: chunk_compare, a combinational CHUNK-bit unsigned compare. It generalises the per-bit compare cells, outputs eq/gt/lt, and is instantiated once on the muxed chunk.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
1. EARLY_EXIT=1, unsigned, a=0x1234, b=0x1234, start at T -> busy for 4 cycles, done after edge T+4, equal=1, a_larger=0, b_larger=0.
2. EARLY_EXIT=1, a=0x8000, b=0x0001 -> done after T+1:
   - signed_mode=0 gives a_larger=1.
   - repeated with signed_mode=1 gives b_larger=1.
3. EARLY_EXIT=1, unsigned, a=0x1235, b=0x1234 -> done after T+4, a_larger=1. EARLY_EXIT=0, a=0xF000, b=0x0000 -> done after T+4 (not T+1), a_larger=1 via sticky flag.
4. Signed corners:
   - 0xFFFF vs 0xFFFE -> a_larger.
   - 0x7FFF vs 0x8000 -> a_larger signed, b_larger unsigned.
   - 0x8000 vs 0x8000 -> equal in both modes.
5. Handshake:
   - start held high during RUN with new operands -> ignored; first result unchanged; exactly one done per accepted start.
   - start asserted in the done cycle -> second compare accepted.
6. Reset: drop rst_n mid-RUN (after T+2) -> busy, done and flags 0 without waiting for clk; no done pulse. After release, a=0x0001, b=0x0002 -> b_larger after T+4.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential chunked magnitude comparator:
// FSM states, one-hot result codes and parameter-derived sizes.
package cmp_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // One-hot result encoding, packed as {equal, a_larger, b_larger}
    localparam logic [2:0] EQ  = 3'b100;
    localparam logic [2:0] AGT = 3'b010;
    localparam logic [2:0] BGT = 3'b001;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int calc_cnt_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunk_compare.sv
// Combinational W-bit unsigned compare built from per-bit equal/greater cells
// resolved from the MSB downwards.
module chunk_compare #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic         gt,
    output logic         lt
);

    logic [W:0]   eq_above;
    logic [W-1:0] gt_bits;
    logic [W-1:0] lt_bits;

    assign eq_above[W] = 1'b1;

    // A bit decides the result only when every more-significant bit is equal
    for (genvar gi = W - 1; gi >= 0; gi--) begin : g_bit
        assign eq_above[gi] = eq_above[gi+1] & ~(a[gi] ^ b[gi]);
        assign gt_bits[gi]  = eq_above[gi+1] & a[gi] & ~b[gi];
        assign lt_bits[gi]  = eq_above[gi+1] & ~a[gi] & b[gi];
    end

    assign eq = eq_above[0];
    assign gt = |gt_bits;
    assign lt = |lt_bits;

endmodule

// File: rtl/compare_seq_n.sv
// Multi-cycle magnitude comparator: scans CHUNK bits per clock from the MSB,
// optionally stopping at the first differing chunk, with a start/done handshake.
module compare_seq_n
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int CHUNK      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             a_larger,
    output logic             b_larger
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int CW     = calc_cnt_width(NCHUNK);

    localparam logic [0:0]       ST_IDLE  = IDLE;
    localparam logic [0:0]       ST_RUN   = RUN;
    localparam logic [CW-1:0]    IDX_TOP  = CW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    logic [0:0]       state_reg;
    logic [CW-1:0]    idx_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             done_reg;
    logic [2:0]       flags_reg;
    logic             sticky_reg;
    logic             sticky_gt_reg;

    logic [CHUNK-1:0] a_chunks [NCHUNK];
    logic [CHUNK-1:0] b_chunks [NCHUNK];
    logic [CHUNK-1:0] a_cur;
    logic [CHUNK-1:0] b_cur;
    logic             c_eq;
    logic             c_gt;
    logic             c_lt;
    logic [WIDTH-1:0] flip;
    logic [2:0]       cur_flags;
    logic [2:0]       fin_flags_next;
    logic             finish_next;

    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
        assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
        assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
    end

    assign a_cur = a_chunks[idx_reg];
    assign b_cur = b_chunks[idx_reg];

    chunk_compare #(.W(CHUNK)) u_chunk_compare (
        .a  (a_cur),
        .b  (b_cur),
        .eq (c_eq),
        .gt (c_gt),
        .lt (c_lt)
    );

    // Offset-binary: flipping both sign bits turns a signed compare into unsigned
    assign flip = signed_mode ? MSB_MASK : '0;

    always_comb begin
        cur_flags      = c_gt ? AGT : (c_lt ? BGT : EQ);
        finish_next    = (idx_reg == '0);
        fin_flags_next = cur_flags;
        if (EARLY_EXIT != 0) begin
            finish_next = finish_next | ~c_eq;
        end else if (sticky_reg) begin
            fin_flags_next = sticky_gt_reg ? AGT : BGT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= IDX_TOP;
            a_reg         <= '0;
            b_reg         <= '0;
            done_reg      <= 1'b0;
            flags_reg     <= 3'b000;
            sticky_reg    <= 1'b0;
            sticky_gt_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == ST_IDLE) begin
                if (start) begin
                    a_reg      <= a ^ flip;
                    b_reg      <= b ^ flip;
                    idx_reg    <= IDX_TOP;
                    sticky_reg <= 1'b0;
                    state_reg  <= ST_RUN;
                end
            end else begin
                if (finish_next) begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b1;
                    flags_reg <= fin_flags_next;
                end else begin
                    idx_reg <= idx_reg - 1'b1;
                    // Only the most significant differing chunk decides
                    if (!sticky_reg && !c_eq) begin
                        sticky_reg    <= 1'b1;
                        sticky_gt_reg <= c_gt;
                    end
                end
            end
        end
    end

    assign busy     = (state_reg == ST_RUN);
    assign done     = done_reg;
    assign equal    = flags_reg[2];
    assign a_larger = flags_reg[1];
    assign b_larger = flags_reg[0];

endmodule

// File: tb/tb_compare_seq_n.sv
// Bench for compare_seq_n: an EARLY_EXIT=1 and an EARLY_EXIT=0 instance share
// stimulus and are checked every cycle against an arithmetic reference model.
module tb_compare_seq_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic busy_w  [2];
    logic done_w  [2];
    logic eq_w    [2];
    logic agt_w   [2];
    logic blt_w   [2];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    compare_seq_n #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1)) dut_ee1 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy_w[1]), .done(done_w[1]),
        .equal(eq_w[1]), .a_larger(agt_w[1]), .b_larger(blt_w[1])
    );

    compare_seq_n #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(0)) dut_ee0 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy_w[0]), .done(done_w[0]),
        .equal(eq_w[0]), .a_larger(agt_w[0]), .b_larger(blt_w[0])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: result from plain integer compare, latency from the position
    // of the most significant differing nibble
    function automatic logic [2:0] ref_flags(input logic [15:0] av, input logic [15:0] bv, input logic sm);
        int x;
        int y;
        x = sm ? int'($signed(av)) : int'(av);
        y = sm ? int'($signed(bv)) : int'(bv);
        if (x == y) return 3'b100;
        return (x > y) ? 3'b010 : 3'b001;
    endfunction

    function automatic int ref_lat(input int ee, input logic [15:0] av, input logic [15:0] bv);
        if (ee == 0) return 4;
        for (int k = 1; k <= 4; k++) begin
            if (av[(4-k)*4 +: 4] != bv[(4-k)*4 +: 4]) return k;
        end
        return 4;
    endfunction

    logic       m_busy  [2] = '{1'b0, 1'b0};
    logic       m_done  [2] = '{1'b0, 1'b0};
    logic [2:0] m_flags [2] = '{3'b000, 3'b000};
    logic [2:0] m_pend  [2] = '{3'b000, 3'b000};
    int         m_left  [2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_busy[d]  = 1'b0;
                m_done[d]  = 1'b0;
                m_flags[d] = 3'b000;
                m_left[d]  = 0;
            end else begin
                m_done[d] = 1'b0;
                if (m_busy[d]) begin
                    m_left[d]--;
                    if (m_left[d] == 0) begin
                        m_busy[d]  = 1'b0;
                        m_done[d]  = 1'b1;
                        m_flags[d] = m_pend[d];
                    end
                end else if (start) begin
                    m_busy[d] = 1'b1;
                    m_left[d] = ref_lat(d, a, b);
                    m_pend[d] = ref_flags(a, b, signed_mode);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busy_ee%0d", d), 32'(busy_w[d]), 32'(m_busy[d]));
                chk($sformatf("done_ee%0d", d), 32'(done_w[d]), 32'(m_done[d]));
                chk($sformatf("flags_ee%0d", d), 32'({eq_w[d], agt_w[d], blt_w[d]}), 32'(m_flags[d]));
            end
        end
    end

    // Called in the low clock phase; returns at the negedge where the later done is seen
    task automatic run_cmp(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                           input bit hold, output int lat1, output int lat0,
                           output logic [2:0] f1, output logic [2:0] f0);
        int n;
        a = av; b = bv; signed_mode = sm; start = 1'b1;
        lat1 = -1; lat0 = -1; f1 = 3'b000; f0 = 3'b000; n = 0;
        while ((lat1 < 0 || lat0 < 0) && n <= 40) begin
            @(negedge clk);
            n++;
            if (hold && n < 3) begin
                a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            if (done_w[1] && lat1 < 0) begin
                lat1 = n - 1; f1 = {eq_w[1], agt_w[1], blt_w[1]};
            end
            if (done_w[0] && lat0 < 0) begin
                lat0 = n - 1; f0 = {eq_w[0], agt_w[0], blt_w[0]};
            end
        end
        start = 1'b0;
        if (lat1 < 0) chk("timeout_ee1", 32'(lat1), 32'(0));
        if (lat0 < 0) chk("timeout_ee0", 32'(lat0), 32'(0));
    endtask

    int l1, l0;
    logic [2:0] f1, f0;
    logic [15:0] ra, rb;

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_flags_ee1", 32'({eq_w[1], agt_w[1], blt_w[1], busy_w[1], done_w[1]}), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_cmp(16'h1234, 16'h1234, 1'b0, 1'b0, l1, l0, f1, f0);
        $display("t1 eq      lat1=%0d lat0=%0d f1=%b f0=%b", l1, l0, f1, f0);
        chk("t1_lat1", 32'(l1), 32'(4)); chk("t1_f1", 32'(f1), 32'(3'b100));
        chk("t1_lat0", 32'(l0), 32'(4)); chk("t1_f0", 32'(f0), 32'(3'b100));

        run_cmp(16'h8000, 16'h0001, 1'b0, 1'b0, l1, l0, f1, f0);
        $display("t2 uns     lat1=%0d lat0=%0d f1=%b f0=%b", l1, l0, f1, f0);
        chk("t2u_lat1", 32'(l1), 32'(1)); chk("t2u_f1", 32'(f1), 32'(3'b010));
        run_cmp(16'h8000, 16'h0001, 1'b1, 1'b0, l1, l0, f1, f0);
        $display("t2 sgn     lat1=%0d lat0=%0d f1=%b f0=%b", l1, l0, f1, f0);
        chk("t2s_lat1", 32'(l1), 32'(1)); chk("t2s_f1", 32'(f1), 32'(3'b001));

        run_cmp(16'h1235, 16'h1234, 1'b0, 1'b0, l1, l0, f1, f0);
        $display("t3 lsb     lat1=%0d lat0=%0d f1=%b f0=%b", l1, l0, f1, f0);
        chk("t3a_lat1", 32'(l1), 32'(4)); chk("t3a_f1", 32'(f1), 32'(3'b010));
        run_cmp(16'hF000, 16'h0000, 1'b0, 1'b0, l1, l0, f1, f0);
        $display("t3 sticky  lat1=%0d lat0=%0d f1=%b f0=%b", l1, l0, f1, f0);
        chk("t3b_lat0", 32'(l0), 32'(4)); chk("t3b_f0", 32'(f0), 32'(3'b010));
        chk("t3b_lat1", 32'(l1), 32'(1));

        run_cmp(16'hFFFF, 16'hFFFE, 1'b1, 1'b0, l1, l0, f1, f0);
        $display("t4 m1m2    f1=%b f0=%b", f1, f0);
        chk("t4a_f1", 32'(f1), 32'(3'b010)); chk("t4a_f0", 32'(f0), 32'(3'b010));
        run_cmp(16'h7FFF, 16'h8000, 1'b1, 1'b0, l1, l0, f1, f0);
        $display("t4 sgn     f1=%b f0=%b", f1, f0);
        chk("t4b_f1", 32'(f1), 32'(3'b010)); chk("t4b_f0", 32'(f0), 32'(3'b010));
        run_cmp(16'h7FFF, 16'h8000, 1'b0, 1'b0, l1, l0, f1, f0);
        $display("t4 uns     f1=%b f0=%b", f1, f0);
        chk("t4c_f1", 32'(f1), 32'(3'b001)); chk("t4c_f0", 32'(f0), 32'(3'b001));
        run_cmp(16'h8000, 16'h8000, 1'b1, 1'b0, l1, l0, f1, f0);
        $display("t4 eq sgn  f1=%b f0=%b", f1, f0);
        chk("t4d_f1", 32'(f1), 32'(3'b100));
        run_cmp(16'h8000, 16'h8000, 1'b0, 1'b0, l1, l0, f1, f0);
        $display("t4 eq uns  f1=%b f0=%b", f1, f0);
        chk("t4e_f1", 32'(f1), 32'(3'b100));

        // start held during RUN with changing operands; result must stay 'equal'
        run_cmp(16'h5A5A, 16'h5A5A, 1'b0, 1'b1, l1, l0, f1, f0);
        $display("t5 hold    lat1=%0d lat0=%0d f1=%b f0=%b", l1, l0, f1, f0);
        chk("t5_lat1", 32'(l1), 32'(4)); chk("t5_f1", 32'(f1), 32'(3'b100));
        chk("t5_f0", 32'(f0), 32'(3'b100));
        // issued in the done cycle of the previous compare
        run_cmp(16'h0003, 16'h0300, 1'b0, 1'b0, l1, l0, f1, f0);
        $display("t5 b2b     lat1=%0d lat0=%0d f1=%b f0=%b", l1, l0, f1, f0);
        chk("t5b_lat1", 32'(l1), 32'(2)); chk("t5b_f1", 32'(f1), 32'(3'b001));

        // asynchronous reset in the middle of a compare
        a = 16'h4444; b = 16'h4444; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t6_async_ee%0d", d),
                32'({busy_w[d], done_w[d], eq_w[d], agt_w[d], blt_w[d]}), 32'(0));
        end
        $display("t6 reset   busy1=%b busy0=%b", busy_w[1], busy_w[0]);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_cmp(16'h0001, 16'h0002, 1'b0, 1'b0, l1, l0, f1, f0);
        $display("t6 after   lat1=%0d lat0=%0d f1=%b f0=%b", l1, l0, f1, f0);
        chk("t6_lat1", 32'(l1), 32'(4)); chk("t6_f1", 32'(f1), 32'(3'b001));
        chk("t6_lat0", 32'(l0), 32'(4)); chk("t6_f0", 32'(f0), 32'(3'b001));

        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 16'($urandom);
                1: rb = ra;
                2: rb = ra ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
                default: rb = ra ^ 16'h8000;
            endcase
            run_cmp(ra, rb, 1'($urandom), 1'b0, l1, l0, f1, f0);
            $display("rand %0d a=%h b=%h sm=%b lat1=%0d lat0=%0d f1=%b f0=%b",
                     i, ra, rb, signed_mode, l1, l0, f1, f0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
